// File: rtl/dilithium_pkg.sv
// Shared Dilithium arithmetic constants and coefficient/product types.
package dilithium_pkg;

    typedef logic [22:0] coeff_t;
    typedef logic [45:0] prod_t;

    localparam coeff_t      DIL_Q             = 23'd8380417;
    localparam logic [23:0] DIL_BARRETT_M     = 24'd8396807;
    localparam int          DIL_BARRETT_SHIFT = 46;

endpackage

// File: rtl/red_D.sv
// Combinational Barrett reducer: maps a product below 2^46 to its residue mod q.
module red_D
    import dilithium_pkg::*;
(
    input  prod_t  prod,
    output coeff_t res
);

    logic [23:0] qhat_s;
    logic [24:0] rem_s;

    // M = floor(2^46 / q), so qhat never exceeds floor(prod / q) and the
    // remainder lands in [0, 2q); a single conditional subtract finishes it.
    assign qhat_s = 24'((70'(prod) * 70'(DIL_BARRETT_M)) >> DIL_BARRETT_SHIFT);
    assign rem_s  = 25'(prod - 46'(qhat_s) * 46'(DIL_Q));

    // Final correction into [0, q-1].
    always_comb begin
        res = rem_s[22:0];
        if (rem_s >= 25'(DIL_Q)) begin
            res = 23'(rem_s - 25'(DIL_Q));
        end else begin
            res = rem_s[22:0];
        end
    end

endmodule

// File: rtl/mulmod_pipe_d.sv
// Three-stage (a*b) mod q multiplier with valid/ready on both sides and a
// bubble-collapsing stall; ready_i reaches ready_o combinationally.
module mulmod_pipe_d
    import dilithium_pkg::*;
#(
    parameter int TAG_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  coeff_t           a_i,
    input  coeff_t           b_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             valid_o,
    input  logic             ready_i,
    output coeff_t           result_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             busy_o
);

    logic             v1_r, v2_r, v3_r;
    coeff_t           a1_r, b1_r;
    prod_t            p2_r;
    coeff_t           r3_r;
    logic [TAG_W-1:0] t1_r, t2_r, t3_r;
    logic             en1_s, en2_s, en3_s;
    coeff_t           red_s;

    // A stage advances when it is empty or its successor is advancing.
    assign en3_s   = !v3_r | ready_i;
    assign en2_s   = !v2_r | en3_s;
    assign en1_s   = !v1_r | en2_s;
    assign ready_o = en1_s;

    // Stage 1: capture operands and tag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v1_r <= 1'b0;
            a1_r <= '0;
            b1_r <= '0;
            t1_r <= '0;
        end else if (en1_s) begin
            v1_r <= valid_i;
            a1_r <= a_i;
            b1_r <= b_i;
            t1_r <= tag_i;
        end
    end

    // Stage 2: full-width 46-bit product.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v2_r <= 1'b0;
            p2_r <= '0;
            t2_r <= '0;
        end else if (en2_s) begin
            v2_r <= v1_r;
            p2_r <= 46'(a1_r) * 46'(b1_r);
            t2_r <= t1_r;
        end
    end

    red_D u_red (
        .prod (p2_r),
        .res  (red_s)
    );

    // Stage 3: reduced residue, drives the output port directly.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v3_r <= 1'b0;
            r3_r <= '0;
            t3_r <= '0;
        end else if (en3_s) begin
            v3_r <= v2_r;
            r3_r <= red_s;
            t3_r <= t2_r;
        end
    end

    assign valid_o  = v3_r;
    assign result_o = r3_r;
    assign tag_o    = t3_r;
    assign busy_o   = v1_r | v2_r | v3_r;

endmodule

// File: tb/tb_mulmod_pipe_d.sv
// Directed and scoreboard bench for mulmod_pipe_d.
module tb_mulmod_pipe_d;
    import dilithium_pkg::*;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       valid_i;
    logic       ready_o;
    coeff_t     a_i, b_i;
    logic [7:0] tag_i;
    logic       valid_o;
    logic       ready_i;
    coeff_t     result_o;
    logic [7:0] tag_o;
    logic       busy_o;

    mulmod_pipe_d #(.TAG_W(8)) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .a_i      (a_i),
        .b_i      (b_i),
        .tag_i    (tag_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .result_o (result_o),
        .tag_o    (tag_o),
        .busy_o   (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        coeff_t     a;
        coeff_t     b;
        logic [7:0] tag;
        coeff_t     exp;
    } vec_t;

    typedef struct {
        coeff_t     res;
        logic [7:0] tag;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    logic lat_chk = 1'b0;

    function automatic coeff_t golden(input coeff_t a, input coeff_t b);
        longint p;
        p = longint'(a) * longint'(b);
        return coeff_t'(p % 64'd8380417);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_emit();
        exp_t e;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_emit: got result %0d tag %0d, expected no output", result_o, tag_o);
        end else begin
            e = sb.pop_front();
            chk("result", 64'(result_o), 64'(e.res));
            chk("tag", 64'(tag_o), 64'(e.tag));
            if (lat_chk) chk("latency", 64'(cyc - e.cyc), 64'd3);
        end
    endtask

    // One clock: drive at negedge, sample 1 time unit later, record handshakes.
    task automatic cycle(input logic v, input coeff_t a, input coeff_t b, input logic [7:0] t,
                         input coeff_t exp, input logic rdy, output logic acc);
        exp_t e;
        @(negedge clk);
        valid_i = v; a_i = a; b_i = b; tag_i = t; ready_i = rdy;
        #1;
        acc = valid_i & ready_o;
        if (valid_o && ready_i) check_emit();
        if (acc) begin
            e.res = exp; e.tag = t; e.cyc = cyc;
            sb.push_back(e);
        end
        cyc++;
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 30 && (sb.size() != 0 || busy_o); i++)
            cycle(1'b0, 23'd0, 23'd0, 8'd0, 23'd0, 1'b1, acc);
        chk("drain_empty", 64'(sb.size()), 64'd0);
        chk("busy_idle", 64'(busy_o), 64'd0);
    endtask

    vec_t   tbl[6];
    coeff_t ba[5];
    coeff_t bb[5];

    initial begin
        logic       acc;
        int         k;
        int         sent;
        logic       have;
        coeff_t     hres;
        logic [7:0] htag;
        coeff_t     ra, rb;

        tbl[0] = '{23'd1,       23'd1,       8'h05, 23'd1};
        tbl[1] = '{23'd8380416, 23'd8380416, 8'h10, 23'd1};
        tbl[2] = '{23'd8380416, 23'd2,       8'h11, 23'd8380415};
        tbl[3] = '{23'd4194304, 23'd2,       8'h12, 23'd8191};
        tbl[4] = '{23'd0,       23'd8380416, 8'h13, 23'd0};
        tbl[5] = '{23'd8380416, 23'd1,       8'h14, 23'd8380416};

        rst_i = 1'b1; valid_i = 1'b0; a_i = '0; b_i = '0; tag_i = '0; ready_i = 1'b1;
        #3;
        chk("rst_valid_o", 64'(valid_o), 64'd0);
        chk("rst_result_o", 64'(result_o), 64'd0);
        chk("rst_tag_o", 64'(tag_o), 64'd0);
        chk("rst_busy_o", 64'(busy_o), 64'd0);
        chk("rst_ready_o", 64'(ready_o), 64'd1);
        @(negedge clk);
        rst_i = 1'b0;

        // Single op, then boundary table back to back.
        lat_chk = 1'b1;
        cycle(1'b1, tbl[0].a, tbl[0].b, tbl[0].tag, tbl[0].exp, 1'b1, acc);
        chk("single_accept", 64'(acc), 64'd1);
        drain();
        for (int i = 1; i < 6; i++) begin
            cycle(1'b1, tbl[i].a, tbl[i].b, tbl[i].tag, tbl[i].exp, 1'b1, acc);
            chk("table_accept", 64'(acc), 64'd1);
        end
        drain();

        // Streaming with ready_i held high.
        for (int i = 0; i < 256; i++) begin
            ra = coeff_t'($urandom_range(0, 8380416));
            rb = coeff_t'($urandom_range(0, 8380416));
            cycle(1'b1, ra, rb, 8'(i), golden(ra, rb), 1'b1, acc);
            if (!acc) chk("stream_accept", 64'(acc), 64'd1);
        end
        drain();
        lat_chk = 1'b0;

        // Backpressure: five offers against a blocked output.
        for (int i = 0; i < 5; i++) begin
            ba[i] = coeff_t'(23'd1000 + 23'(i));
            bb[i] = coeff_t'(23'd8380000 - 23'(i));
        end
        k = 0; have = 1'b0; hres = '0; htag = '0;
        for (int c = 0; c < 8; c++) begin
            cycle(k < 5, ba[k < 5 ? k : 0], bb[k < 5 ? k : 0], 8'(8'h40 + k),
                  golden(ba[k < 5 ? k : 0], bb[k < 5 ? k : 0]), 1'b0, acc);
            if (acc) k++;
            if (valid_o) begin
                if (!have) begin
                    hres = result_o; htag = tag_o; have = 1'b1;
                end else begin
                    chk("stall_result_stable", 64'(result_o), 64'(hres));
                    chk("stall_tag_stable", 64'(tag_o), 64'(htag));
                end
            end
        end
        chk("stall_accepts", 64'(k), 64'd3);
        chk("stall_ready_o", 64'(ready_o), 64'd0);
        chk("stall_valid_o", 64'(valid_o), 64'd1);
        chk("stall_held_tag", 64'(htag), 64'h40);
        for (int c = 0; c < 40 && k < 5; c++) begin
            cycle(1'b1, ba[k], bb[k], 8'(8'h40 + k), golden(ba[k], bb[k]), 1'b1, acc);
            if (acc) k++;
        end
        chk("release_accepts", 64'(k), 64'd5);
        drain();

        // Random valid/ready traffic against the scoreboard.
        sent = 0;
        for (int c = 0; c < 60000 && sent < 10000; c++) begin
            ra = coeff_t'($urandom_range(0, 8380416));
            rb = coeff_t'($urandom_range(0, 8380416));
            cycle(1'($urandom_range(0, 1)), ra, rb, 8'(sent), golden(ra, rb),
                  1'($urandom_range(0, 1)), acc);
            if (acc) sent++;
        end
        chk("random_sent", 64'(sent), 64'd10000);
        drain();

        // Asynchronous reset with three ops in flight.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 23'd7 + 23'(i), 23'd9, 8'(8'h60 + i), golden(23'd7 + 23'(i), 23'd9), 1'b0, acc);
            chk("inflight_accept", 64'(acc), 64'd1);
        end
        @(negedge clk);
        valid_i = 1'b0; ready_i = 1'b0;
        #1;
        chk("pre_reset_valid_o", 64'(valid_o), 64'd1);
        #1;
        rst_i = 1'b1;
        #1;
        chk("async_reset_valid_o", 64'(valid_o), 64'd0);
        chk("async_reset_busy_o", 64'(busy_o), 64'd0);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        for (int c = 0; c < 6; c++) cycle(1'b0, 23'd0, 23'd0, 8'd0, 23'd0, 1'b1, acc);
        cycle(1'b1, 23'd3, 23'd5, 8'h77, 23'd15, 1'b1, acc);
        chk("post_reset_accept", 64'(acc), 64'd1);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
